// File: rtl/game_timer.sv
// Configurable game clock: prescaled time steps, up/down counting with wrap or
// stop-at-terminal, and start/pause/clear/load control.
module game_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 50_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dir,
  input  logic             i_wrap,
  output logic [WIDTH-1:0] o_time,
  output logic             o_tick,
  output logic             o_expire,
  output logic             o_running,
  output logic [1:0]       o_state
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PRE_ONE   = PW'(1);
  localparam logic [WIDTH-1:0] TIME_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] time_q, time_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             expire_q, expire_d;
  logic             running_q, running_d;

  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] stepVal;
  logic             stepFire;
  logic             stepExpire;
  logic             startOk;

  // Terminal and candidate step follow the live i_dir so a direction change
  // takes effect on the very next step.
  assign terminal   = i_dir ? '0 : '1;
  assign stepVal    = i_dir ? (time_q - TIME_ONE) : (time_q + TIME_ONE);
  assign stepFire   = (state_q == RUN) && (pre_q == PRE_LAST);
  assign stepExpire = (stepVal == terminal);
  assign startOk    = i_start && !(!i_wrap && (time_q == terminal));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      time_q    <= '0;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      expire_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      expire_q  <= expire_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    pre_d    = pre_q;
    tick_d   = 1'b0;
    expire_d = 1'b0;

    if (i_clear) begin
      time_d  = '0;
      pre_d   = '0;
      state_d = IDLE;
    end else if (i_load) begin
      time_d = i_load_val;
      pre_d  = '0;
      if (state_q == DONE) begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (stepFire) begin
            pre_d    = '0;
            time_d   = stepVal;
            tick_d   = 1'b1;
            expire_d = stepExpire;
            // Stopping at terminal outranks a pause requested on the same cycle.
            if (stepExpire && !i_wrap) begin
              state_d = DONE;
            end else if (i_pause) begin
              state_d = PAUSE;
            end
          end else begin
            pre_d = pre_q + PRE_ONE;
            if (i_pause) begin
              state_d = PAUSE;
            end
          end
        end
        PAUSE: begin
          if (startOk) begin
            state_d = RUN;
          end
        end
        IDLE, DONE: begin
          if (startOk) begin
            state_d = RUN;
            pre_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    running_d = (state_d == RUN);
  end

  assign o_time    = time_q;
  assign o_tick    = tick_q;
  assign o_expire  = expire_q;
  assign o_running = running_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: a directed vector table, corner-case sequences and
// random stimulus on two configurations, all scored against a behavioural model.
module tb_game_timer;

  localparam int WA = 4;
  localparam int PA = 4;
  localparam int WB = 2;
  localparam int PB = 1;

  logic clk = 1'b0;
  logic rstN = 1'b1;
  logic clr = 1'b0, ld = 1'b0, st = 1'b0, pa = 1'b0, dir = 1'b0, wr = 1'b0;
  logic [3:0] lv = '0;

  logic [WA-1:0] timeA;
  logic          tickA, expA, runA;
  logic [1:0]    stA;
  logic [WB-1:0] timeB;
  logic          tickB, expB, runB;
  logic [1:0]    stB;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  game_timer #(.WIDTH(WA), .PRESCALE(PA)) dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_start(st), .i_pause(pa), .i_clear(clr),
    .i_load(ld), .i_load_val(lv), .i_dir(dir), .i_wrap(wr),
    .o_time(timeA), .o_tick(tickA), .o_expire(expA), .o_running(runA), .o_state(stA)
  );

  game_timer #(.WIDTH(WB), .PRESCALE(PB)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_start(st), .i_pause(pa), .i_clear(clr),
    .i_load(ld), .i_load_val(lv[1:0]), .i_dir(dir), .i_wrap(wr),
    .o_time(timeB), .o_tick(tickB), .o_expire(expB), .o_running(runB), .o_state(stB)
  );

  // Model: mode 0=idle 1=run 2=pause 3=done; runCycles counts RUN cycles since last step.
  typedef struct {
    int t;
    int runCycles;
    int mode;
    bit tick;
    bit expire;
  } mdl_t;

  mdl_t mA, mB;

  function automatic mdl_t mReset();
    mdl_t m;
    m.t = 0; m.runCycles = 0; m.mode = 0; m.tick = 0; m.expire = 0;
    return m;
  endfunction

  function automatic mdl_t mStep(mdl_t m, int w, int p, bit c, bit l, int v,
                                 bit s, bit ps, bit d, bit wp);
    mdl_t n = m;
    int modulus = 1 << w;
    int term = d ? 0 : modulus - 1;
    n.tick = 0;
    n.expire = 0;
    if (c) begin
      n.t = 0; n.runCycles = 0; n.mode = 0;
    end else if (l) begin
      n.t = v % modulus; n.runCycles = 0;
      if (m.mode == 3) n.mode = 0;
    end else if (m.mode == 1) begin
      n.runCycles = m.runCycles + 1;
      if (n.runCycles == p) begin
        n.runCycles = 0;
        n.t = (m.t + (d ? modulus - 1 : 1)) % modulus;
        n.tick = 1;
        n.expire = (n.t == term);
        if (n.expire && !wp) n.mode = 3;
        else if (ps) n.mode = 2;
      end else if (ps) begin
        n.mode = 2;
      end
    end else if (s && !(!wp && m.t == term)) begin
      n.mode = 1;
      if (m.mode != 2) n.runCycles = 0;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic compareAll();
    checkOutput("A.time", timeA, mA.t);
    checkOutput("A.tick", tickA, mA.tick);
    checkOutput("A.expire", expA, mA.expire);
    checkOutput("A.state", stA, mA.mode);
    checkOutput("A.running", runA, mA.mode == 1);
    checkOutput("B.time", timeB, mB.t);
    checkOutput("B.tick", tickB, mB.tick);
    checkOutput("B.expire", expB, mB.expire);
    checkOutput("B.state", stB, mB.mode);
    checkOutput("B.running", runB, mB.mode == 1);
  endtask

  task automatic applyStimulus(input bit c, input bit l, input int v, input bit s,
                               input bit ps, input bit d, input bit wp);
    clr = c; ld = l; lv = 4'(v); st = s; pa = ps; dir = d; wr = wp;
    @(posedge clk);
    mA = mStep(mA, WA, PA, clr, ld, int'(lv), st, pa, dir, wr);
    mB = mStep(mB, WB, PB, clr, ld, int'(lv[1:0]), st, pa, dir, wr);
    #1;
    compareAll();
  endtask

  typedef struct {
    bit c, l; int v; bit s, ps, d, wp;
    int expTime; bit expTick, expExp; int expState;
  } vec_t;

  vec_t tbl[40];

  function automatic vec_t mk(bit c, bit l, int v, bit s, bit ps, bit d, bit wp,
                              int t, bit tk, bit ex, int sst);
    vec_t r;
    r.c = c; r.l = l; r.v = v; r.s = s; r.ps = ps; r.d = d; r.wp = wp;
    r.expTime = t; r.expTick = tk; r.expExp = ex; r.expState = sst;
    return r;
  endfunction

  initial begin
    int tickCnt, expCnt, tickCntB, expCntB;
    bit found;

    // Directed table for the WIDTH=4, PRESCALE=4 instance.
    tbl[0]  = mk(0,0,0, 1,0,0,1,  0,0,0,1);
    for (int i = 1; i <= 3; i++) tbl[i] = mk(0,0,0, 0,0,0,1,  0,0,0,1);
    tbl[4]  = mk(0,0,0, 0,0,0,1,  1,1,0,1);
    tbl[5]  = mk(0,0,0, 0,1,0,1,  1,0,0,2);
    tbl[6]  = mk(0,0,0, 0,0,0,1,  1,0,0,2);
    tbl[7]  = mk(0,0,0, 1,0,0,1,  1,0,0,1);
    tbl[8]  = mk(0,0,0, 0,0,0,1,  1,0,0,1);
    tbl[9]  = mk(0,0,0, 0,0,0,1,  1,0,0,1);
    tbl[10] = mk(0,0,0, 0,0,0,1,  2,1,0,1);
    tbl[11] = mk(0,1,7, 0,0,0,1,  7,0,0,1);
    for (int i = 12; i <= 14; i++) tbl[i] = mk(0,0,0, 0,0,0,1,  7,0,0,1);
    tbl[15] = mk(0,0,0, 0,0,0,1,  8,1,0,1);
    tbl[16] = mk(0,0,0, 1,1,0,1,  8,0,0,2);
    tbl[17] = mk(1,1,5, 1,0,0,1,  0,0,0,0);
    tbl[18] = mk(0,1,3, 0,0,0,1,  3,0,0,0);
    tbl[19] = mk(0,0,0, 1,0,1,0,  3,0,0,1);
    for (int i = 20; i <= 22; i++) tbl[i] = mk(0,0,0, 0,0,1,0,  3,0,0,1);
    tbl[23] = mk(0,0,0, 0,0,1,0,  2,1,0,1);
    for (int i = 24; i <= 26; i++) tbl[i] = mk(0,0,0, 0,0,1,0,  2,0,0,1);
    tbl[27] = mk(0,0,0, 0,0,1,0,  1,1,0,1);
    for (int i = 28; i <= 30; i++) tbl[i] = mk(0,0,0, 0,0,1,0,  1,0,0,1);
    tbl[31] = mk(0,0,0, 0,0,1,0,  0,1,1,3);
    tbl[32] = mk(0,0,0, 1,0,1,0,  0,0,0,3);
    tbl[33] = mk(0,0,0, 0,0,1,0,  0,0,0,3);
    tbl[34] = mk(0,1,14, 0,0,0,0, 14,0,0,0);
    tbl[35] = mk(0,0,0, 1,0,0,0,  14,0,0,1);
    for (int i = 36; i <= 38; i++) tbl[i] = mk(0,0,0, 0,0,0,0,  14,0,0,1);
    tbl[39] = mk(0,0,0, 0,0,0,0,  15,1,1,3);

    // Reset with an edge while asserted.
    #2 rstN = 1'b0;
    mA = mReset();
    mB = mReset();
    @(posedge clk);
    @(posedge clk);
    #1 rstN = 1'b1;
    #1 compareAll();

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].c, tbl[i].l, tbl[i].v, tbl[i].s, tbl[i].ps, tbl[i].d, tbl[i].wp);
      checkOutput($sformatf("tbl[%0d].time", i), timeA, tbl[i].expTime);
      checkOutput($sformatf("tbl[%0d].tick", i), tickA, tbl[i].expTick);
      checkOutput($sformatf("tbl[%0d].expire", i), expA, tbl[i].expExp);
      checkOutput($sformatf("tbl[%0d].state", i), stA, tbl[i].expState);
    end

    // DONE holds the terminal value with no ticks.
    tickCnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tickCnt += int'(tickA);
    end
    checkOutput("doneHold.ticks", tickCnt, 0);
    checkOutput("doneHold.time", timeA, 15);

    // Full up-count wrap cycle on both instances.
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    tickCnt = 0; expCnt = 0; tickCntB = 0; expCntB = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      tickCnt += int'(tickA); expCnt += int'(expA);
      tickCntB += int'(tickB); expCntB += int'(expB);
    end
    checkOutput("wrapA.ticks", tickCnt, 16);
    checkOutput("wrapA.expires", expCnt, 1);
    checkOutput("wrapA.time", timeA, 0);
    checkOutput("wrapA.state", stA, 1);
    checkOutput("wrapB.ticks", tickCntB, 64);
    checkOutput("wrapB.expires", expCntB, 16);

    // PRESCALE=1 down count with wrap from 1.
    applyStimulus(1, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 1, 1);
    checkOutput("downB.start", timeB, 1);
    tickCntB = 0; expCntB = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 1);
      tickCntB += int'(tickB); expCntB += int'(expB);
    end
    checkOutput("downB.ticks", tickCntB, 8);
    checkOutput("downB.expires", expCntB, 2);
    checkOutput("downB.time", timeB, 1);

    // Asynchronous reset mid-run at time 5.
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      if (timeA == 4'd5) found = 1;
    end
    checkOutput("reachFive", int'(found), 1);
    rstN = 1'b0;
    #1;
    checkOutput("asyncRst.time", timeA, 0);
    checkOutput("asyncRst.tick", tickA, 0);
    checkOutput("asyncRst.expire", expA, 0);
    checkOutput("asyncRst.running", runA, 0);
    checkOutput("asyncRst.state", stA, 0);
    mA = mReset();
    mB = mReset();
    @(posedge clk);
    #1 rstN = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("postRst.state", stA, 0);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                    int'($urandom_range(0, 15)), $urandom_range(0, 5) == 0,
                    $urandom_range(0, 11) == 0,
                    (i / 97) % 2 == 1 ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 19) == 0),
                    (i / 211) % 2 == 0 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
